conv_channel_accum_gen: RTL and testbench
=========================================

# conv_channel_accum_gen

Parametrised channel accumulator for the 3x3 convolution path. It sits after the per-channel 3x3 convolution engine and sums the partial-result planes of all input channels into one output plane per output channel. It generalises the fixed 128-channel adder:
- channel counts, image size and accumulator width are parameters;
- stride-2 plane sizing is selected at run time;
- the output is saturated, with optional ReLU.

## Interface
Parameters:
- DATA_WIDTH, 16: signed two's-complement sample width.
- ACC_WIDTH, 24: internal accumulator width; must be ≥ DATA_WIDTH + clog2(CHANNEL_NUM_IN).
- IMAGE_WIDTH, 128: output plane width at stride 1; even, ≥ 4.
- IMAGE_HEIGHT, 128: output plane height at stride 1; even, ≥ 4.
- CHANNEL_NUM_IN, 128: number of partial planes summed per output channel; ≥ 1.
- CHANNEL_NUM_OUT, 128: number of output channels per frame; ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stride2  in  1  1 selects a (IMAGE_WIDTH/2)×(IMAGE_HEIGHT/2) plane; sampled only at group start.
- valid_in  in  1  pxl_in is valid this cycle. There is no back-pressure.
- pxl_in  in  DATA_WIDTH  partial-sum sample.
- pxl_out  out  DATA_WIDTH  accumulated, saturated sample.
- valid_out  out  1  pxl_out is valid.
- last_out  out  1  marks the final pixel of the final output channel in the frame.

## Operation
- Input order:
  - For each output channel oc, CHANNEL_NUM_IN planes arrive back to back.
  - Each plane is PLANE samples in row-major order.
  - PLANE = IMAGE_WIDTH·IMAGE_HEIGHT, or a quarter of that when stride2 is latched.
- Counters advance only on valid_in:
  - pix_cnt runs 0..PLANE-1 and wraps to 0.
  - ch_cnt increments when pix_cnt wraps and runs 0..CHANNEL_NUM_IN-1.
  - oc_cnt increments when ch_cnt wraps and runs 0..CHANNEL_NUM_OUT-1; then the frame restarts.
- stride2 is latched into s2_q on a valid_in with pix_cnt = 0 and ch_cnt = 0. It is ignored at all other times.
- Accumulation buffer: IMAGE_WIDTH·IMAGE_HEIGHT words of ACC_WIDTH bits, with synchronous read and synchronous write.
- Stage 0 (valid_in cycle): register sign-extended pxl_in, pix_cnt, first = (ch_cnt == 0) and last = (ch_cnt == CHANNEL_NUM_IN-1). Issue a read at pix_cnt.
- Stage 1:
  - sum = (first ? 0 : rd_data) + in_q, wrapping modulo 2^ACC_WIDTH.
  - Write sum back to the same address.
  - If last, compute the output.
- Output computation:
  - Clamp sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register the clamped value to pxl_out and raise valid_out.
  - Raise last_out together with valid_out when the sample is pix PLANE-1 of oc CHANNEL_NUM_OUT-1.
- Read-after-write hazard: none. The same address is revisited at least PLANE ≥ 4 valid cycles later, so no bypass is needed.
- The first plane overwrites stale contents, so the buffer is never cleared.
- Reset (asserted at any time, including mid-plane):
  - pix_cnt, ch_cnt, oc_cnt, s2_q and pipeline valids go to 0.
  - pxl_out = 0, valid_out = 0, last_out = 0.
  - The buffer is not cleared.
  - After release, the next valid_in is treated as pixel 0, channel 0, oc 0.

## Timing
- Latency: valid_out rises exactly 2 cycles after the valid_in that carries the final-plane sample.
- Throughput: one sample per cycle. Idle cycles in valid_in propagate one-for-one into valid_out gaps.
- Between outputs, valid_out and last_out are low. pxl_out holds its last value.
- Output rate: per output channel, exactly PLANE valid_out pulses, all occurring during the final input plane.

## Configuration
- CONV_ACC_RELU_EN:
  - Defined: after clamping, any negative value is output as 0, so pxl_out is never negative.
  - Undefined: the signed clamped value passes unchanged.
- Counters, latency and last_out are identical in both builds.

## Test plan
Bench parameters: DATA_WIDTH=16, ACC_WIDTH=24, IMAGE_WIDTH=IMAGE_HEIGHT=4, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2.
1. Basic accumulation, stride2=0: 96 samples of pxl_in=1 -> 32 outputs of 3; oc0 outputs start 2 cycles after input #33; last_out only on output #32.
2. Pixel distinctness: plane c, pixel p carries value p+16c -> output p equals 3p+48.
3. Saturation: all samples 20000 -> 32767; all samples -20000 -> -32768 without CONV_ACC_RELU_EN, 0 with it.
4. Stride: stride2=1 at group start, toggled mid-group -> plane 4; 12 inputs yield 4 outputs per oc; the mid-group toggle is ignored.
5. Throttling: random 50% valid_in gaps -> outputs bit-identical to scenario 2; each valid_out is exactly 2 cycles after its source input.
6. Mid-operation reset: reset low during plane 1 of oc0 -> all outputs 0 the same cycle; after release, a full scenario 1 sequence reproduces scenario 1 results with no stale data.

Source files
------------

// File: rtl/conv_channel_accum_gen.sv
// Channel accumulator: sums CHANNEL_NUM_IN partial planes per output channel and saturates the result.
// Optional build macro CONV_ACC_RELU_EN clamps negative results to zero.
module conv_channel_accum_gen #(
  parameter int DATA_WIDTH      = 16,
  parameter int ACC_WIDTH       = 24,
  parameter int IMAGE_WIDTH     = 128,
  parameter int IMAGE_HEIGHT    = 128,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stride2,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                         valid_out,
  output logic                         last_out
);

  localparam int PLANE_FULL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_W     = $clog2(PLANE_FULL);
  localparam int CH_W       = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
  localparam int OC_W       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [ADDR_W-1:0] PIX_LAST_FULL = ADDR_W'(PLANE_FULL - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST_S2   = ADDR_W'(PLANE_FULL / 4 - 1);
  localparam logic [CH_W-1:0]   CH_LAST       = CH_W'(CHANNEL_NUM_IN - 1);
  localparam logic [OC_W-1:0]   OC_LAST       = OC_W'(CHANNEL_NUM_OUT - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Saturate the wide sum into the output range, then optionally rectify.
  function automatic logic [DATA_WIDTH-1:0] f_clamp(input logic signed [ACC_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] res;
    if (v > SAT_MAX) begin
      res = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      res = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      res = v[DATA_WIDTH-1:0];
    end
`ifdef CONV_ACC_RELU_EN
    res = res[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : res;
`else
    res = res;
`endif
    return res;
  endfunction

  logic [ADDR_W-1:0]           r_pix_cnt;
  logic [CH_W-1:0]             r_ch_cnt;
  logic [OC_W-1:0]             r_oc_cnt;
  logic                        r_s2;

  logic                        r_v0;
  logic signed [ACC_WIDTH-1:0] r_in_q;
  logic [ADDR_W-1:0]           r_addr_q;
  logic                        r_first_q;
  logic                        r_last_q;
  logic                        r_final_q;

  logic [ACC_WIDTH-1:0]        r_mem [PLANE_FULL];
  logic [ACC_WIDTH-1:0]        r_rd_data;

  logic [ADDR_W-1:0]           w_pix_last;
  logic                        w_pix_wrap;
  logic                        w_ch_wrap;
  logic                        w_group_start;
  logic signed [ACC_WIDTH-1:0] w_sum;

  // Position decode; a plane always has at least 4 pixels, so pixel 0 never wraps.
  always_comb begin
    w_pix_last    = r_s2 ? PIX_LAST_S2 : PIX_LAST_FULL;
    w_pix_wrap    = (r_pix_cnt == w_pix_last);
    w_ch_wrap     = (r_ch_cnt == CH_LAST);
    w_group_start = (r_pix_cnt == {ADDR_W{1'b0}}) && (r_ch_cnt == {CH_W{1'b0}});
  end

  // Pixel / channel / output-channel counters and stride latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_cnt <= {ADDR_W{1'b0}};
      r_ch_cnt  <= {CH_W{1'b0}};
      r_oc_cnt  <= {OC_W{1'b0}};
      r_s2      <= 1'b0;
    end else if (valid_in) begin
      if (w_group_start) begin
        r_s2 <= stride2;
      end
      if (w_pix_wrap) begin
        r_pix_cnt <= {ADDR_W{1'b0}};
        if (w_ch_wrap) begin
          r_ch_cnt <= {CH_W{1'b0}};
          r_oc_cnt <= (r_oc_cnt == OC_LAST) ? {OC_W{1'b0}} : r_oc_cnt + OC_W'(1);
        end else begin
          r_ch_cnt <= r_ch_cnt + CH_W'(1);
        end
      end else begin
        r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
      end
    end
  end

  // Stage 0: capture the sample and its position tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v0      <= 1'b0;
      r_in_q    <= {ACC_WIDTH{1'b0}};
      r_addr_q  <= {ADDR_W{1'b0}};
      r_first_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_final_q <= 1'b0;
    end else begin
      r_v0 <= valid_in;
      if (valid_in) begin
        r_in_q    <= ACC_WIDTH'(pxl_in);
        r_addr_q  <= r_pix_cnt;
        r_first_q <= (r_ch_cnt == {CH_W{1'b0}});
        r_last_q  <= w_ch_wrap;
        r_final_q <= w_pix_wrap && w_ch_wrap && (r_oc_cnt == OC_LAST);
      end
    end
  end

  // Partial-sum buffer; deliberately not reset since the first plane overwrites it.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_rd_data <= r_mem[r_pix_cnt];
    end
    if (r_v0) begin
      r_mem[r_addr_q] <= w_sum;
    end
  end

  // Stage 1 sum, wrapping in ACC_WIDTH.
  always_comb begin
    w_sum = (r_first_q ? {ACC_WIDTH{1'b0}} : r_rd_data) + r_in_q;
  end

  // Output register: only the final input plane produces samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out   <= {DATA_WIDTH{1'b0}};
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else if (r_v0 && r_last_q) begin
      pxl_out   <= f_clamp(w_sum);
      valid_out <= 1'b1;
      last_out  <= r_final_q;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_channel_accum_gen.sv
// Self-checking bench for conv_channel_accum_gen against a plane-sum reference model.
module tb_conv_channel_accum_gen;

  localparam int DW   = 16;
  localparam int AW   = 24;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int CIN  = 3;
  localparam int COUT = 2;
  localparam int PF   = IW * IH;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 stride2;
  logic                 valid_in;
  logic signed [DW-1:0] pxl_in;
  logic signed [DW-1:0] pxl_out;
  logic                 valid_out;
  logic                 last_out;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  conv_channel_accum_gen #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
    .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT)
  ) dut (
    .clk(clk), .reset(reset), .stride2(stride2), .valid_in(valid_in),
    .pxl_in(pxl_in), .pxl_out(pxl_out), .valid_out(valid_out), .last_out(last_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus and expectations
  int in_v[$];
  bit in_s[$];
  int drv_cyc[$];
  int exp_v[$];
  bit exp_l[$];
  int exp_src[$];

  // Observed outputs
  bit mon_en = 1'b0;
  int obs_v[$];
  bit obs_l[$];
  int obs_c[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out) begin
        obs_v.push_back(int'(pxl_out));
        obs_l.push_back(last_out);
        obs_c.push_back(cyc);
      end else if (last_out) begin
        vectors++;
        errors++;
        $display("FAIL last_without_valid at cycle %0d: got last_out=1 expected 0", cyc);
      end
    end
  end

  function automatic int sat(input int s);
    int r;
    r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
`ifdef CONV_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic int gen_val(input int mode, input int c, input int p);
    case (mode)
      0: return 1;
      1: return p + 16 * c;
      2: return 20000;
      3: return -20000;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Build one full frame of stimulus and its expected output stream.
  task automatic build(input int mode, input bit s2, input bit toggle);
    int idx = 0;
    in_v.delete(); in_s.delete(); exp_v.delete(); exp_l.delete(); exp_src.delete();
    for (int oc = 0; oc < COUT; oc++) begin
      int plane = s2 ? PF / 4 : PF;
      int acc[PF];
      for (int p = 0; p < PF; p++) acc[p] = 0;
      for (int c = 0; c < CIN; c++) begin
        for (int p = 0; p < plane; p++) begin
          int v = gen_val(mode, c, p);
          in_v.push_back(v);
          in_s.push_back((c == 0 && p == 0) ? s2 : (toggle ? ~s2 : s2));
          acc[p] += v;
          if (c == CIN - 1) exp_src.push_back(idx);
          idx++;
        end
      end
      for (int p = 0; p < plane; p++) begin
        exp_v.push_back(sat(acc[p]));
        exp_l.push_back(oc == COUT - 1 && p == plane - 1);
      end
    end
  endtask

  // Drive the first n samples with random idle gaps; entered and left at posedge+1.
  task automatic drive(input int gap_pct, input int n);
    drv_cyc.delete();
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        valid_in = 1'b0;
        stride2  = 1'($urandom);
        pxl_in   = DW'($urandom);
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      pxl_in   = DW'(in_v[i]);
      stride2  = in_s[i];
      drv_cyc.push_back(cyc);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic check(input string name);
    int n;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (obs_v.size() !== exp_v.size()) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, obs_v.size(), exp_v.size());
    end
    n = (obs_v.size() < exp_v.size()) ? obs_v.size() : exp_v.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_v[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL %s value[%0d]: got %0d expected %0d", name, i, obs_v[i], exp_v[i]);
      end
      vectors++;
      if (obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s last[%0d]: got %0d expected %0d", name, i, obs_l[i], exp_l[i]);
      end
      vectors++;
      if (obs_c[i] !== drv_cyc[exp_src[i]] + 2) begin
        errors++;
        $display("FAIL %s latency[%0d]: got cycle %0d expected %0d", name, i, obs_c[i],
                 drv_cyc[exp_src[i]] + 2);
      end
    end
    obs_v.delete(); obs_l.delete(); obs_c.delete();
  endtask

  task automatic run(input string name, input int mode, input bit s2, input bit toggle,
                     input int gap_pct);
    build(mode, s2, toggle);
    drive(gap_pct, in_v.size());
    check(name);
  endtask

  task automatic test_reset;
    reset = 1'b0; valid_in = 1'b0; stride2 = 1'b0; pxl_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pxl_out !== 16'sd0 || valid_out !== 1'b0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pxl=%0d v=%0b l=%0b expected 0 0 0", pxl_out, valid_out, last_out);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;         run("basic", 0, 1'b0, 1'b0, 0);        endtask
  task automatic test_distinct;      run("distinct", 1, 1'b0, 1'b0, 0);     endtask
  task automatic test_saturation;
    run("sat_pos", 2, 1'b0, 1'b0, 0);
    run("sat_neg", 3, 1'b0, 1'b0, 0);
  endtask
  task automatic test_stride;
    run("stride2", 1, 1'b1, 1'b1, 0);
    run("stride1_toggle", 1, 1'b0, 1'b1, 0);
  endtask
  task automatic test_throttle;      run("throttle", 1, 1'b0, 1'b0, 50);    endtask
  task automatic test_back_to_back;  run("random", 4, 1'b0, 1'b0, 20);      endtask

  task automatic test_mid_reset;
    build(1, 1'b0, 1'b0);
    drive(0, PF + 5);
    reset    = 1'b0;
    valid_in = 1'b1;
    #1;
    vectors++;
    if (pxl_out !== 16'sd0 || valid_out !== 1'b0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got pxl=%0d v=%0b l=%0b expected 0 0 0", pxl_out, valid_out, last_out);
    end
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs_v.delete(); obs_l.delete(); obs_c.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    run("after_reset", 0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_distinct();
    test_saturation();
    test_stride();
    test_throttle();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
